// File: rtl/sni_sdram_arbiter_if.sv
// Bundle of the two requester ports, the SDRAM controller port and vblank.
// Latency: none, this only groups wires.
// Backpressure: none, requesters and controller use single-cycle pulses.
interface sni_sdram_arbiter_if;
    logic        vblank;

    logic [24:0] a_addr;
    logic [7:0]  a_data;
    logic        a_rd_req;
    logic        a_wr_req;
    logic        a_ready;
    logic [7:0]  a_q;

    logic [24:0] b_addr;
    logic [7:0]  b_data;
    logic        b_rd_req;
    logic        b_wr_req;
    logic        b_ready;
    logic [7:0]  b_q;

    logic [24:0] m_addr;
    logic [7:0]  m_data;
    logic        m_rd_req;
    logic        m_wr_req;
    logic        m_ready;
    logic [7:0]  m_q;

    // Arbiter side: it receives the requester ports and drives the controller.
    modport slave (
        input  vblank,
        input  a_addr, a_data, a_rd_req, a_wr_req,
        output a_ready, a_q,
        input  b_addr, b_data, b_rd_req, b_wr_req,
        output b_ready, b_q,
        output m_addr, m_data, m_rd_req, m_wr_req,
        input  m_ready, m_q
    );

    // Environment side: requesters plus the SDRAM controller.
    modport master (
        output vblank,
        output a_addr, a_data, a_rd_req, a_wr_req,
        input  a_ready, a_q,
        output b_addr, b_data, b_rd_req, b_wr_req,
        input  b_ready, b_q,
        input  m_addr, m_data, m_rd_req, m_wr_req,
        output m_ready, m_q
    );
endinterface

// File: rtl/sni_sdram_arbiter.sv
// Shares one byte-wide SDRAM request port between the SNES core (A, priority) and SNI debug (B).
// Latency: request pulse to m_*_req 2 cycles minimum; m_ready to X_ready 1 cycle.
// Backpressure: one slot per port; a pulse while that port is pending or in flight is dropped.
// Build option SNI_VBLANK_ONLY_EN: port B may only be granted while vblank=1.
module sni_sdram_arbiter #(
    // Consecutive A grants tolerated while B waits (1..15).
    parameter int unsigned MAX_DEFER = 4
) (
    input  logic               clk,
    input  logic               reset,
    sni_sdram_arbiter_if.slave bus
);
    localparam logic [3:0] MAX_DEFER_C = 4'(MAX_DEFER);

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        we;
    } req_slot_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } state_t;

    state_t      state;
    req_slot_t   slot_a;
    req_slot_t   slot_b;
    logic        pend_a;
    logic        pend_b;
    logic        cur_we;
    logic [3:0]  defer_cnt;

    logic [24:0] m_addr_r;
    logic [7:0]  m_data_r;
    logic        m_rd_r;
    logic        m_wr_r;
    logic        a_ready_r;
    logic        b_ready_r;
    logic [7:0]  a_q_r;
    logic [7:0]  b_q_r;

    logic        a_take;
    logic        b_take;
    logic        b_eligible;
    logic        grant_a;
    logic        grant_b;

    assign bus.m_addr   = m_addr_r;
    assign bus.m_data   = m_data_r;
    assign bus.m_rd_req = m_rd_r;
    assign bus.m_wr_req = m_wr_r;
    assign bus.a_ready  = a_ready_r;
    assign bus.a_q      = a_q_r;
    assign bus.b_ready  = b_ready_r;
    assign bus.b_q      = b_q_r;

`ifndef SNI_VBLANK_ONLY_EN
    logic unused_vblank;
    assign unused_vblank = bus.vblank;
`endif

    // Capture qualification and grant decision. The m_ready cycle already counts as
    // finished, so a requester that re-pulses then is armed for the next IDLE cycle;
    // that is what lets A win repeatedly and makes the defer bound meaningful.
    always_comb begin
        a_take = (bus.a_rd_req | bus.a_wr_req) & ~pend_a
                 & ~((state == BUSY_A) & ~bus.m_ready);
        b_take = (bus.b_rd_req | bus.b_wr_req) & ~pend_b
                 & ~((state == BUSY_B) & ~bus.m_ready);
`ifdef SNI_VBLANK_ONLY_EN
        b_eligible = pend_b & bus.vblank;
`else
        b_eligible = pend_b;
`endif
        grant_a = (state == IDLE) & pend_a
                  & (~b_eligible | (defer_cnt < MAX_DEFER_C));
        grant_b = (state == IDLE) & ~grant_a & b_eligible;
    end

    // Request slots: latch address, data and direction when a pulse is accepted;
    // rd and wr together is stored as a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_a <= '0;
            slot_b <= '0;
        end else begin
            if (a_take) begin
                slot_a <= '{addr: bus.a_addr, data: bus.a_data, we: bus.a_wr_req};
            end
            if (b_take) begin
                slot_b <= '{addr: bus.b_addr, data: bus.b_data, we: bus.b_wr_req};
            end
        end
    end

    // Arbitration FSM: issue one transfer at a time, hold the address bus while busy,
    // and route the completion and read data back to the owning port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pend_a    <= 1'b0;
            pend_b    <= 1'b0;
            cur_we    <= 1'b0;
            m_addr_r  <= '0;
            m_data_r  <= '0;
            m_rd_r    <= 1'b0;
            m_wr_r    <= 1'b0;
            a_ready_r <= 1'b0;
            b_ready_r <= 1'b0;
            a_q_r     <= '0;
            b_q_r     <= '0;
        end else begin
            m_rd_r    <= 1'b0;
            m_wr_r    <= 1'b0;
            a_ready_r <= 1'b0;
            b_ready_r <= 1'b0;
            pend_a    <= (pend_a & ~grant_a) | a_take;
            pend_b    <= (pend_b & ~grant_b) | b_take;

            case (state)
                IDLE: begin
                    if (grant_a) begin
                        state    <= BUSY_A;
                        m_addr_r <= slot_a.addr;
                        m_data_r <= slot_a.data;
                        m_wr_r   <= slot_a.we;
                        m_rd_r   <= ~slot_a.we;
                        cur_we   <= slot_a.we;
                    end else if (grant_b) begin
                        state    <= BUSY_B;
                        m_addr_r <= slot_b.addr;
                        m_data_r <= slot_b.data;
                        m_wr_r   <= slot_b.we;
                        m_rd_r   <= ~slot_b.we;
                        cur_we   <= slot_b.we;
                    end
                end
                BUSY_A: begin
                    if (bus.m_ready) begin
                        state     <= IDLE;
                        a_ready_r <= 1'b1;
                        if (!cur_we) begin
                            a_q_r <= bus.m_q;
                        end
                    end
                end
                BUSY_B: begin
                    if (bus.m_ready) begin
                        state     <= IDLE;
                        b_ready_r <= 1'b1;
                        if (!cur_we) begin
                            b_q_r <= bus.m_q;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Starvation bound: count A grants taken while B waits, saturating; any cycle with
    // B not waiting, or a B grant, restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            defer_cnt <= '0;
        end else if (grant_b) begin
            defer_cnt <= '0;
        end else if (grant_a && pend_b) begin
            if (defer_cnt < MAX_DEFER_C) begin
                defer_cnt <= defer_cnt + 4'd1;
            end
        end else if (!pend_b) begin
            defer_cnt <= '0;
        end
    end

    // A grant issues exactly one strobe, and only the owning port sees a completion.
    a_one_strobe: assert property (@(posedge clk) disable iff (reset) !(m_rd_r && m_wr_r));
    a_one_ready:  assert property (@(posedge clk) disable iff (reset) !(a_ready_r && b_ready_r));

endmodule

// File: doc/sni_sdram_arbiter.md
Name: sni_sdram_arbiter

Overview:
- Shares the single byte-wide SDRAM request port between two requesters.
- Port A is the SNES core memory path and has priority.
- Port B is the SNI UART debug engine.
- Both requesters use single-cycle rd/wr request pulses and a single-cycle ready completion pulse.
- The block latches the requests, serializes them onto the SDRAM controller, and routes each completion and its read data back to the originating port.
- A defer counter bounds how long port B can be starved.

Parameters:
- MAX_DEFER, 4: number of consecutive A grants allowed while B is pending before B is forced the next grant. Range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vblank  in  1  SNES vblank level; used only with SNI_VBLANK_ONLY_EN
- a_addr  in  25  port A byte address
- a_data  in  8  port A write data
- a_rd_req  in  1  port A read request pulse
- a_wr_req  in  1  port A write request pulse
- a_ready  out  1  port A completion pulse
- a_q  out  8  port A read data
- b_addr  in  25  port B byte address
- b_data  in  8  port B write data
- b_rd_req  in  1  port B read request pulse
- b_wr_req  in  1  port B write request pulse
- b_ready  out  1  port B completion pulse
- b_q  out  8  port B read data
- m_addr  out  25  address to the SDRAM controller
- m_data  out  8  write data to the SDRAM controller
- m_rd_req  out  1  read request pulse to the SDRAM controller
- m_wr_req  out  1  write request pulse to the SDRAM controller
- m_ready  in  1  SDRAM controller completion pulse
- m_q  in  8  SDRAM controller read data

Behaviour:
- Reset clears all pend/busy flags, defer_cnt, and every output: m_*, a_*, b_* all 0. State returns to IDLE. A transfer in flight at reset is abandoned; its later m_ready arrives in IDLE and is ignored.
- Capture: a rd or wr pulse on port X in cycle T latches {addr, data, we} into slot X and sets pend_X.
  - rd and wr asserted together: treated as a write.
  - A pulse while port X is already pending or in flight is dropped; the slot is unchanged.
- FSM has three states: IDLE, BUSY_A, BUSY_B.
- IDLE: grant is evaluated only on pend flags that were already set (registered), so there is no same-cycle bypass.
  - pend_A and (not pend_B or defer_cnt < MAX_DEFER): go to BUSY_A.
  - Else if pend_B: go to BUSY_B.
  - On the grant cycle: m_addr/m_data load from the slot, exactly one of m_rd_req/m_wr_req pulses for 1 cycle, and pend_X clears.
- BUSY_X: m_addr/m_data are held stable. On m_ready:
  - Next cycle, X_ready pulses for 1 cycle.
  - For reads, X_q is loaded from m_q (sampled in the m_ready cycle).
  - State returns to IDLE.
- Latency: request pulse at T, m_*_req at T+2 at the earliest, X_ready at R+1 where m_ready arrives at R. Back-to-back grants are separated by one IDLE cycle.
- X_q holds its value until the next read completion on that port; writes leave it unchanged.
- defer_cnt (4 bits):
  - Increments on each A grant made while pend_B is set, saturating at MAX_DEFER.
  - Clears on a B grant, or in any cycle where pend_B is 0.
- m_ready while IDLE is ignored. The other port's ready never pulses.

Optional Feature:
- SNI_VBLANK_ONLY_EN defined:
  - B may be granted only in cycles where vblank=1, including the starvation-forced grant.
  - While vblank=0, B stays pending and A is served normally.
  - defer_cnt still counts and saturates.
  - A B transfer in flight completes regardless of vblank.
- SNI_VBLANK_ONLY_EN undefined: vblank is ignored.

Test Plan:
- Single A read: a_rd_req at T with a_addr=0x000123. Expect m_rd_req at T+2 with m_addr=0x000123. Return m_ready with m_q=0x5A at T+5. Expect a_ready at T+6, a_q=0x5A, b_ready stays 0.
- Simultaneous requests: a_wr_req and b_rd_req in the same cycle. Expect the A write issued first; B read issued only after a_ready, with one IDLE gap; b_q gets the returned data.
- Starvation with MAX_DEFER=4: A re-requests continuously while B is pending. Expect exactly 4 A grants, then a B grant, then defer_cnt=0.
- Overrun: second b_wr_req while B is pending, carrying different data. Expect exactly one m_wr_req for B, with the first data value.
- Reset mid-transfer: reset while in BUSY_B, then m_ready arrives after reset. Expect no a_ready/b_ready, all outputs 0, and normal operation on the next request.
- With SNI_VBLANK_ONLY_EN, vblank=0: b_rd_req is held off. Raise vblank=1 and expect m_rd_req for B on the next IDLE grant cycle.
